// File: rtl/femtosoc_bus.sv
// femtosoc_bus: RAM / one-hot IO / flash fabric for the FemtoRV32 core, with reset delay and sticky bus error.
// Optional busy-timeout tracker enabled by defining FEMTOSOC_BUS_TIMEOUT_EN.
module femtosoc_bus #(
  parameter int unsigned RAM_BYTES        = 6144,
  parameter int unsigned N_IO             = 8,
  parameter int unsigned RESET_DELAY_BITS = 12,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wmask,
  input  logic                  mem_rstrb,
  output logic [31:0]           mem_rdata,
  output logic                  mem_rbusy,
  output logic                  mem_wbusy,
  output logic                  cpu_reset_n,
  output logic                  io_rstrb,
  output logic                  io_wstrb,
  output logic [19:0]           io_word_address,
  output logic [31:0]           io_wdata,
  input  logic [32*N_IO-1:0]    io_rdata,
  input  logic [N_IO-1:0]       io_rbusy,
  input  logic [N_IO-1:0]       io_wbusy,
  output logic                  flash_rstrb,
  output logic [19:0]           flash_word_address,
  input  logic [31:0]           flash_rdata,
  input  logic                  flash_rbusy,
  input  logic                  brk,
  output logic                  error,
  output logic [23:0]           err_addr
);

  localparam int unsigned WORDS = RAM_BYTES / 4;
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [19:0] WORDS_W = 20'(WORDS);

  typedef enum logic [1:0] {REG_RAM = 2'b00, REG_IO = 2'b01, REG_FLASH = 2'b10, REG_NONE = 2'b11} region_e;

  region_e     region;
  logic        wstrb, any_strb, unmapped_strb;
  logic        raw_rbusy, raw_wbusy, raw_busy;
  logic        tmo_mask, tmo_hit;
  logic [23:0] tmo_addr;
  logic [19:0] word_idx;
  logic [AW-1:0] ram_idx;
  logic [31:0] ram [WORDS];
  logic [31:0] ram_rdata_q, io_rdata_q, io_or;
  logic [RESET_DELAY_BITS-1:0] dly_q, dly_d;
  logic        error_q, error_d;
  logic [23:0] err_addr_q, err_addr_d;
  logic        unused_bits;

  assign region        = region_e'(mem_addr[23:22]);
  assign wstrb         = |mem_wmask;
  assign any_strb      = mem_rstrb | wstrb;
  assign unmapped_strb = any_strb & (region == REG_NONE);

  assign io_rstrb           = mem_rstrb & (region == REG_IO);
  assign io_wstrb           = wstrb & (region == REG_IO);
  assign flash_rstrb        = mem_rstrb & (region == REG_FLASH);
  assign io_word_address    = mem_addr[21:2];
  assign flash_word_address = mem_addr[21:2];
  assign io_wdata           = mem_wdata;

  assign word_idx    = mem_addr[21:2] % WORDS_W;
  assign ram_idx     = word_idx[AW-1:0];
  assign unused_bits = ^{mem_addr[31:24], mem_addr[1:0], word_idx};

  always_ff @(posedge clk) begin
    if (wstrb && region == REG_RAM) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_wmask[b]) ram[ram_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    io_or = '0;
    for (int unsigned k = 0; k < N_IO; k++) io_or = io_or | io_rdata[32*k +: 32];
  end

  always_comb begin
    unique case (region)
      REG_RAM:   mem_rdata = ram_rdata_q;
      REG_IO:    mem_rdata = io_rdata_q;
      REG_FLASH: mem_rdata = flash_rdata;
      default:   mem_rdata = '0;
    endcase
  end

  assign raw_rbusy = (|io_rbusy) | flash_rbusy;
  assign raw_wbusy = |io_wbusy;
  assign raw_busy  = raw_rbusy | raw_wbusy;
  assign mem_rbusy = raw_rbusy & ~tmo_mask;
  assign mem_wbusy = raw_wbusy & ~tmo_mask;

`ifdef FEMTOSOC_BUS_TIMEOUT_EN
  typedef enum logic {ST_IDLE, ST_WAIT} state_e;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] tcount_q, tcount_d;
  logic        tmo_mask_q, tmo_mask_d;
  logic [23:0] taddr_q, taddr_d;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      tcount_q   <= '0;
      tmo_mask_q <= 1'b0;
      taddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      tcount_q   <= tcount_d;
      tmo_mask_q <= tmo_mask_d;
      taddr_q    <= taddr_d;
    end
  end

  // Mask release (busy drop / new strobe) is applied first so a timeout on the same edge wins.
  always_comb begin
    state_d    = state_q;
    tcount_d   = tcount_q;
    tmo_mask_d = tmo_mask_q;
    taddr_d    = taddr_q;
    tmo_hit    = 1'b0;
    if (!raw_busy || any_strb) tmo_mask_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_strb && (region == REG_IO || region == REG_FLASH)) begin
          state_d  = ST_WAIT;
          tcount_d = '0;
          taddr_d  = mem_addr[23:0];
        end
      end
      ST_WAIT: begin
        if (!raw_busy) begin
          state_d = ST_IDLE;
        end else if (tcount_q == TMO_LAST) begin
          state_d    = ST_IDLE;
          tmo_mask_d = 1'b1;
          tmo_hit    = 1'b1;
        end else begin
          tcount_d = tcount_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmo_mask = tmo_mask_q;
  assign tmo_addr = taddr_q;
`else
  assign tmo_mask = 1'b0;
  assign tmo_hit  = 1'b0;
  assign tmo_addr = '0;
`endif

  always_comb begin
    error_d    = error_q;
    err_addr_d = err_addr_q;
    dly_d      = (&dly_q) ? dly_q : dly_q + RESET_DELAY_BITS'(1);
    if (!error_q) begin
      if (tmo_hit) begin
        error_d    = 1'b1;
        err_addr_d = tmo_addr;
      end else if (unmapped_strb) begin
        error_d    = 1'b1;
        err_addr_d = mem_addr[23:0];
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ram_rdata_q <= '0;
      io_rdata_q  <= '0;
      dly_q       <= '0;
      error_q     <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      ram_rdata_q <= ram[ram_idx];
      io_rdata_q  <= io_or;
      dly_q       <= dly_d;
      error_q     <= error_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign cpu_reset_n = (&dly_q) & ~brk;
  assign error       = error_q;
  assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_femtosoc_bus.sv
// Self-checking bench for femtosoc_bus: read data checked through an expected-value queue.
module tb_femtosoc_bus;
  localparam int unsigned N_IO = 8;

  logic              clk = 1'b0;
  logic              RESET;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_wmask;
  logic              mem_rstrb, mem_rbusy, mem_wbusy, cpu_reset_n;
  logic              io_rstrb, io_wstrb, flash_rstrb;
  logic [19:0]       io_word_address, flash_word_address;
  logic [31:0]       io_wdata, flash_rdata;
  logic [32*N_IO-1:0] io_rdata;
  logic [N_IO-1:0]   io_rbusy, io_wbusy;
  logic              flash_rbusy, brk, error;
  logic [23:0]       err_addr;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];

  femtosoc_bus #(
    .RAM_BYTES(6144), .N_IO(N_IO), .RESET_DELAY_BITS(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .RESET(RESET), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .cpu_reset_n(cpu_reset_n),
    .io_rstrb(io_rstrb), .io_wstrb(io_wstrb), .io_word_address(io_word_address),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_rbusy(io_rbusy), .io_wbusy(io_wbusy),
    .flash_rstrb(flash_rstrb), .flash_word_address(flash_word_address),
    .flash_rdata(flash_rdata), .flash_rbusy(flash_rbusy), .brk(brk),
    .error(error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, mem_rdata, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    tick();
    mem_wmask = 4'b0000;
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] e);
    mem_addr = a; mem_rstrb = 1'b1;
    exp_q.push_back(e);
    #1 chk({tag, "_rbusy"}, 32'(mem_rbusy), 32'd0);
    tick();
    mem_rstrb = 1'b0;
    sb_pop(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hi;
    RESET = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
    io_rdata = '0; io_rbusy = '0; io_wbusy = '0; flash_rdata = '0; flash_rbusy = 1'b0; brk = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    flash_rbusy = 1'b1; io_wbusy[2] = 1'b1;
    #1 chk("rst_rbusy_follow", 32'(mem_rbusy), 32'd1);
    chk("rst_wbusy_follow", 32'(mem_wbusy), 32'd1);
    flash_rbusy = 1'b0; io_wbusy = '0;
    #1 chk("rst_rbusy_low", 32'(mem_rbusy), 32'd0);

    // reset delay: 15 cycles with 4-bit counter
    RESET = 1'b0;
    repeat (14) tick();
    chk("dly_14", 32'(cpu_reset_n), 32'd0);
    tick();
    chk("dly_15", 32'(cpu_reset_n), 32'd1);
    brk = 1'b1;
    #1 chk("brk_on", 32'(cpu_reset_n), 32'd0);
    repeat (3) tick();
    brk = 1'b0;
    #1 chk("brk_off", 32'(cpu_reset_n), 32'd1);

    // RAM byte-masked writes, read latency, read-during-write, index wrap
    ram_wr(32'h0000_0010, 32'h1122_3344, 4'b1111);
    ram_wr(32'h0000_0010, 32'hAABB_CCDD, 4'b0100);
    rd_reg("ram_mask", 32'h0000_0010, 32'h11BB_3344);
    mem_wdata = 32'hCAFE_F00D; mem_wmask = 4'b1111;
    rd_reg("ram_rdw_old", 32'h0000_0010, 32'h11BB_3344);
    mem_wmask = 4'b0000;
    rd_reg("ram_rdw_new", 32'h0000_0010, 32'hCAFE_F00D);
    ram_wr(32'h0000_1800, 32'h5A5A_0001, 4'b1111);
    rd_reg("ram_wrap", 32'h0000_0000, 32'h5A5A_0001);

    // IO read from slot 1, then OR of two slots
    io_rdata[32*1 +: 32] = 32'h0000_00A5;
    mem_addr = 32'h0040_0004; mem_rstrb = 1'b1;
    #1 chk("io_rstrb", 32'(io_rstrb), 32'd1);
    chk("io_word_address", 32'(io_word_address), 32'h1);
    chk("io_flash_rstrb", 32'(flash_rstrb), 32'd0);
    mem_rstrb = 1'b0;
    rd_reg("io_slot1", 32'h0040_0004, 32'h0000_00A5);
    io_rdata = '0;
    io_rdata[32*0 +: 32] = 32'h0000_0F00;
    io_rdata[32*5 +: 32] = 32'h0000_00F0;
    rd_reg("io_or", 32'h0040_0008, 32'h0000_0FF0);
    io_rdata = '0;

    // IO write strobe with short write busy
    mem_addr = 32'h0040_0010; mem_wdata = 32'h0BAD_BEEF; mem_wmask = 4'b0011;
    #1 chk("io_wstrb", 32'(io_wstrb), 32'd1);
    chk("io_wdata", io_wdata, 32'h0BAD_BEEF);
    chk("io_wr_no_rstrb", 32'(io_rstrb), 32'd0);
    tick();
    mem_wmask = 4'b0000; io_wbusy[3] = 1'b1;
    #1 chk("io_wbusy", 32'(mem_wbusy), 32'd1);
    tick(); tick();
    io_wbusy = '0;
    #1 chk("io_wbusy_rel", 32'(mem_wbusy), 32'd0);
    tick();

    // flash read with 5 busy cycles; flash write dropped
    flash_rdata = 32'h1357_9BDF;
    mem_addr = 32'h0082_0000; mem_rstrb = 1'b1;
    exp_q.push_back(32'h1357_9BDF);
    #1 chk("flash_rstrb", 32'(flash_rstrb), 32'd1);
    chk("flash_word_address", 32'(flash_word_address), 32'h08000);
    sb_pop("flash_pass");
    tick();
    mem_rstrb = 1'b0; flash_rbusy = 1'b1; hi = 0;
    for (int i = 0; i < 5; i++) begin
      #1 if (mem_rbusy) hi++;
      tick();
    end
    flash_rbusy = 1'b0;
    #1 chk("flash_busy_cycles", hi, 32'd5);
    chk("flash_busy_rel", 32'(mem_rbusy), 32'd0);
    chk("flash_no_err", 32'(error), 32'd0);
    mem_wmask = 4'b1111;
    #1 chk("flash_wr_no_io", 32'(io_wstrb | flash_rstrb), 32'd0);
    tick();
    mem_wmask = 4'b0000;
    chk("flash_wr_no_err", 32'(error), 32'd0);

    // stuck flash busy: timeout releases after 8 busy cycles when enabled
    mem_addr = 32'h0082_0000; mem_rstrb = 1'b1;
    tick();
    mem_rstrb = 1'b0; flash_rbusy = 1'b1; hi = 0;
    mem_addr = 32'h0000_0020;
    for (int i = 0; i < 12; i++) begin
      #1 if (mem_rbusy) hi++;
      tick();
    end
`ifdef FEMTOSOC_BUS_TIMEOUT_EN
    chk("tmo_busy_cycles", hi, 32'd8);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_err_addr", 32'(err_addr), 32'h0082_0000);
`else
    chk("tmo_busy_cycles", hi, 32'd12);
    chk("tmo_error", 32'(error), 32'd0);
    chk("tmo_err_addr", 32'(err_addr), 32'd0);
`endif
    flash_rbusy = 1'b0;
    tick();

    // reset mid-operation clears state and registered data
    RESET = 1'b1;
    #1 chk("rst2_error", 32'(error), 32'd0);
    chk("rst2_err_addr", 32'(err_addr), 32'd0);
    chk("rst2_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    mem_addr = 32'h0000_0010;
    #1 chk("rst2_rdata", mem_rdata, 32'd0);
    tick();
    RESET = 1'b0;
    tick();

    // unmapped access sets sticky error; second one keeps first address
    rd_reg("unmapped_rdata", 32'h00C0_0100, 32'd0);
    chk("unmapped_error", 32'(error), 32'd1);
    chk("unmapped_err_addr", 32'(err_addr), 32'h00C0_0100);
    rd_reg("unmapped2_rdata", 32'h00C0_0200, 32'd0);
    chk("unmapped2_err_addr", 32'(err_addr), 32'h00C0_0100);
    chk("unmapped2_error", 32'(error), 32'd1);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/femtosoc_bus.md
Name: femtosoc_bus

Overview:
- Parametrised memory/IO fabric between the FemtoRV32 core and its RAM, one-hot IO page and mapped SPI flash page; next generation of the fixed single-board SoC glue.
- Owns:
  - the internal byte-masked BRAM of configurable size;
  - N one-hot IO slots with a registered, OR-combined read-back;
  - busy aggregation;
  - the startup reset-delay generator;
  - a sticky bus-error flag (unmapped access, optional busy timeout) that drives the board error LED.

Parameters:
- RAM_BYTES, 6144: internal RAM size in bytes, multiple of 4.
- N_IO, 8: number of one-hot IO slots, 1..20.
- RESET_DELAY_BITS, 12: width of the startup delay counter; delay is 2^RESET_DELAY_BITS-1 cycles.
- TIMEOUT_CYCLES, 255: maximum busy cycles per transaction before forced release, 2..65535.

Ports:
- clk  in  1  system clock
- RESET  in  1  asynchronous active-high reset
- mem_addr  in  32  core byte address; bits [23:2] used
- mem_wdata  in  32  core write data
- mem_wmask  in  4  byte write mask; write strobe = OR of mask
- mem_rstrb  in  1  core read strobe
- mem_rdata  out  32  read data to core
- mem_rbusy  out  1  read busy to core
- mem_wbusy  out  1  write busy to core
- cpu_reset_n  out  1  active-low reset to core
- io_rstrb  out  1  read strobe qualified to IO page
- io_wstrb  out  1  write strobe qualified to IO page
- io_word_address  out  20  mem_addr[21:2]
- io_wdata  out  32  copy of mem_wdata
- io_rdata  in  32*N_IO  per-slot read data; slot k at [32k+31:32k]
- io_rbusy  in  N_IO  per-slot read busy
- io_wbusy  in  N_IO  per-slot write busy
- flash_rstrb  out  1  read strobe qualified to flash page
- flash_word_address  out  20  mem_addr[21:2]
- flash_rdata  in  32  flash read data
- flash_rbusy  in  1  flash read busy
- brk  in  1  UART break; holds the core in reset
- error  out  1  sticky bus error
- err_addr  out  24  mem_addr[23:0] of the first error

Behaviour:
- Address decode on mem_addr[23:22]:
  - 00 = RAM
  - 01 = IO
  - 10 = flash
  - 11 = unmapped
- Strobe qualification: io_rstrb/io_wstrb/flash_rstrb are combinational ANDs of the core strobes with the region decode. Flash has no write path; writes to flash are silently dropped.
- RAM:
  - word index = mem_addr[21:2] modulo RAM_BYTES/4.
  - Writes on the clk edge with byte enables per mem_wmask.
  - Read data is registered every cycle (1-cycle latency, no busy). Read-during-write returns old data.
- IO read data: registered OR of all N_IO slot words, 1-cycle latency. Slots must drive 0 when not selected.
- mem_rdata mux, combinational from current decode: IO → registered IO data; RAM → RAM data; flash → flash_rdata; unmapped → 0.
- Busy aggregation:
  - raw_rbusy = OR(io_rbusy) | flash_rbusy.
  - raw_wbusy = OR(io_wbusy).
  - mem_rbusy = raw_rbusy & ~tmo_mask; mem_wbusy = raw_wbusy & ~tmo_mask.
- Reset delay:
  - Counter cleared by RESET; increments each cycle until all-ones, then holds.
  - cpu_reset_n = (counter all-ones) & ~brk.
  - brk does not restart the counter.
- Transaction tracker states: IDLE, WAIT.
  - IDLE→WAIT: on any strobe to IO or flash. The 16-bit tcount is cleared and tmo_mask is cleared on that same edge.
  - WAIT→IDLE: when raw busy is low. tcount increments while busy.
  - Timeout: if tcount reaches TIMEOUT_CYCLES-1 while busy, set tmo_mask=1, go to IDLE and record an error.
  - tmo_mask stays set until raw busy drops or the next strobe.
- Error recording:
  - Sources: a strobe to the unmapped region, or a timeout.
  - If error is 0 on the triggering edge: error←1 and err_addr←mem_addr[23:0]. For a timeout, err_addr is the address latched at WAIT entry.
  - Later errors do not overwrite err_addr.
  - Cleared only by RESET.
- Simultaneous rstrb and wstrb: both are forwarded and counted as one transaction.
- Strobes while cpu_reset_n=0 are still decoded (the core does not issue them).
- RESET mid-operation:
  - state=IDLE, tcount=0, tmo_mask=0, error=0, err_addr=0, delay counter=0.
  - Registered read data = 0; cpu_reset_n=0.
- Reset values of outputs:
  - mem_rdata = 0 for an RAM/IO address before the first clk edge.
  - mem_rbusy and mem_wbusy follow their inputs.
  - cpu_reset_n=0, error=0, err_addr=0.

Optional Feature:
- Macro FEMTOSOC_BUS_TIMEOUT_EN.
- Defined: WAIT state, tcount, tmo_mask and timeout error are present as described.
- Undefined:
  - Tracker and tcount are removed; tmo_mask is constant 0.
  - Busy passes straight through.
  - Only unmapped accesses set error.

Test Plan:
- Release RESET, brk=0 with RESET_DELAY_BITS=4 → cpu_reset_n stays 0 for 15 cycles, rises on cycle 15; asserting brk drops it combinationally, and deasserting brk restores it without recount.
- RAM write 32'h11223344 to 0x000010 with mask 4'b1111, then mask 4'b0100 with wdata 32'hAABBCCDD → read of 0x000010 returns 32'h11BB3344 one cycle after rstrb, mem_rbusy=0.
- IO read at 0x400004 with slot1 driving 32'h000000A5 and other slots 0 → io_rstrb=1, io_word_address=20'h00001, mem_rdata=32'h000000A5 on the next cycle.
- Flash read at 0x820000 with flash_rbusy held 5 cycles → mem_rbusy high exactly 5 cycles, flash_rdata passed through, error stays 0.
- Read at 0xC00100 → mem_rdata=0, error=1, err_addr=24'hC00100; a subsequent unmapped read at 0xC00200 leaves err_addr unchanged.
- With FEMTOSOC_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, flash_rbusy stuck high → mem_rbusy drops after 8 busy cycles, error=1, err_addr=24'h820000. Without the macro, mem_rbusy stays high and error stays 0.
